// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR pattern generator and its receive-side checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } checker_state_t;

  localparam int DEFAULT_REGISTER_LENGTH = 8;
  localparam int DEFAULT_LOCK_COUNT      = 16;
  localparam int DEFAULT_LOSS_COUNT      = 4;

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfsr_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_sequence_checker.sv
// Self-synchronising LFSR sequence checker with lock detection and bit-error flagging.
// Define LFSR_CHECKER_ERR_COUNT_EN to build the saturating error_count; otherwise it reads 0.
module lfsr_sequence_checker
  import lfsr_pkg::*;
#(
  parameter int REGISTER_LENGTH = DEFAULT_REGISTER_LENGTH,
  parameter int LOCK_COUNT      = DEFAULT_LOCK_COUNT,
  parameter int LOSS_COUNT      = DEFAULT_LOSS_COUNT,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     bit_in,
  input  logic                     clear_errors,
  output logic                     locked,
  output logic                     bit_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count
);

  localparam int FILL_W = $clog2(REGISTER_LENGTH + 1);
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  checker_state_t             state;
  logic [REGISTER_LENGTH-1:0] hist;
  logic [FILL_W-1:0]          fill_cnt;
  logic [RUN_W-1:0]           run_cnt;
  logic [MISS_W-1:0]          miss_cnt;

  logic prediction;
  logic match;
  logic hist_zero;
  logic count_error;

  // hist[0] is the newest accepted bit, hist[N-1] the oldest
  assign prediction  = hist[REGISTER_LENGTH-1] ^ hist[REGISTER_LENGTH-2];
  assign match       = (bit_in == prediction);
  assign hist_zero   = (hist == '0);
  assign count_error = enable && (state == LOCKED) && !match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      hist      <= '0;
      fill_cnt  <= '0;
      run_cnt   <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      bit_error <= 1'b0;
    end else begin
      bit_error <= 1'b0;
      if (enable) begin
        hist <= {hist[REGISTER_LENGTH-2:0], bit_in};
        case (state)
          FILL: begin
            if (int'(fill_cnt) == REGISTER_LENGTH - 1) begin
              state    <= HUNT;
              fill_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          HUNT: begin
            // an all-zero history predicts 0 forever, so such matches prove nothing
            if (match && !hist_zero) begin
              if (int'(run_cnt) == LOCK_COUNT - 1) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                run_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                run_cnt <= run_cnt + 1'b1;
              end
            end else begin
              run_cnt <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              miss_cnt <= '0;
            end else begin
              bit_error <= 1'b1;
              if (int'(miss_cnt) == LOSS_COUNT - 1) begin
                state    <= HUNT;
                locked   <= 1'b0;
                miss_cnt <= '0;
                run_cnt  <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= FILL;
          end
        endcase
      end
    end
  end

`ifdef LFSR_CHECKER_ERR_COUNT_EN
  lfsr_sat_counter #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (count_error),
    .clear (clear_errors),
    .count (error_count)
  );
`else
  logic unused_err_inputs;
  assign unused_err_inputs = clear_errors ^ count_error;
  assign error_count       = '0;
`endif

endmodule
